// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_e : receiver FSM state encoding (3 bits)
//   maj3       : 2-of-3 majority vote used to filter the sampled line
// `UART_DATA_WIDTH sets the default frame width (8 unless overridden).
// -----------------------------------------------------------------------------
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif

package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = `UART_DATA_WIDTH;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_MIN_DIVIDE  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Two-of-three vote: a single-cycle spike on the line cannot flip a sample.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// N-flop synchroniser for a single asynchronous input.
//   clk  : destination clock
//   rst  : synchronous, active-high reset; all flops load RESET_VAL
//   d    : asynchronous input
//   q    : synchronised output (STAGES cycles of latency)
// RESET_VAL lets the caller preload the chain with the line's idle level.
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the input through the flop chain; reset fills it with the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 (LSB first) serial receiver feeding the UART slave's rx FIFO.
//   clk, rst       : system clock, synchronous active-high reset
//   rxd            : serial input, idle high, asynchronous to clk
//   uart_divide    : clocks per bit, clamped below at MIN_DIVIDE
//   uart_rx_data   : last good byte, held until the next good frame
//   uart_rx_valid  : one-cycle pulse per good frame (FIFO write enable)
//   uart_rx_err    : one-cycle pulse when the stop bit is sampled low
//   active         : high whenever the receiver is not idle
// The divider is captured at the start edge, so a divide change only
// affects the following frame.
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned MIN_DIVIDE  = DEFAULT_MIN_DIVIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [31:0]           uart_divide,
    output logic [DATA_WIDTH-1:0] uart_rx_data,
    output logic                  uart_rx_valid,
    output logic                  uart_rx_err,
    output logic                  active
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rxd_s;
    logic                  rxd_prev_r;
    logic [2:0]            hist_r;
    logic                  samp_s;
    logic                  fall_s;
    logic                  tick_s;
    logic [31:0]           div_s;
    logic [31:0]           div_q_r;
    logic [31:0]           cnt_r;
    logic [IDX_W-1:0]      bit_idx_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    rx_state_e             state_r;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Edge-detect delay and 3-sample history of the synchronised line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_prev_r <= 1'b1;
            hist_r     <= 3'b111;
        end else begin
            rxd_prev_r <= rxd_s;
            hist_r     <= {hist_r[1:0], rxd_s};
        end
    end

    assign samp_s = maj3(hist_r);
    assign fall_s = rxd_prev_r & ~rxd_s;
    assign tick_s = (cnt_r == 32'd0);
    assign div_s  = (uart_divide < 32'(MIN_DIVIDE)) ? 32'(MIN_DIVIDE) : uart_divide;

    // Receiver FSM with bit counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 32'd0;
            div_q_r       <= 32'd0;
            bit_idx_r     <= {IDX_W{1'b0}};
            shreg_r       <= {DATA_WIDTH{1'b0}};
            uart_rx_data  <= {DATA_WIDTH{1'b0}};
            uart_rx_valid <= 1'b0;
            uart_rx_err   <= 1'b0;
            active        <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        // Half a bit to land in the middle of the start bit.
                        cnt_r   <= div_s >> 1;
                        div_q_r <= div_s;
                        state_r <= START;
                        active  <= 1'b1;
                    end else begin
                        active  <= 1'b0;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (!samp_s) begin
                            cnt_r     <= div_q_r - 32'd1;
                            bit_idx_r <= {IDX_W{1'b0}};
                            state_r   <= DATA;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch.
                            state_r <= IDLE;
                            active  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shreg_r <= {samp_s, shreg_r[DATA_WIDTH-1:1]};
                        cnt_r   <= div_q_r - 32'd1;
                        if (bit_idx_r == IDX_W'(DATA_WIDTH - 1)) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (samp_s) begin
                            // Return to IDLE at mid stop bit so a back-to-back
                            // start edge is still caught.
                            uart_rx_data  <= shreg_r;
                            uart_rx_valid <= 1'b1;
                            state_r       <= IDLE;
                            active        <= 1'b0;
                        end else begin
                            uart_rx_err <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r - 32'd1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line without re-reporting it.
                    if (rxd_s) begin
                        state_r <= IDLE;
                        active  <= 1'b0;
                    end else begin
                        state_r <= BREAK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core: drives 8N1 frames on rxd and checks the
// received bytes, pulses and the active flag against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [31:0] uart_divide;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_err;
    logic        active;

    int     n_assert = 0;
    int     n_fail   = 0;
    int     valid_cnt = 0;
    int     err_cnt   = 0;
    int     both_cnt  = 0;
    longint cyc       = 0;
    longint t_fall    = 0;
    longint t_valid   = 0;
    logic [7:0] rx_q[$];

    uart_rx_core dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .uart_divide   (uart_divide),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_err   (uart_rx_err),
        .active        (active)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (uart_rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            rx_q.push_back(uart_rx_data);
            t_valid <= cyc;
        end
        if (uart_rx_err) err_cnt <= err_cnt + 1;
        if (uart_rx_valid && uart_rx_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; optionally change uart_divide at the start of bit chg_bit.
    task automatic send_frame(input logic [7:0] data, input int bit_clks, input logic stop,
                              input int chg_bit, input logic [31:0] chg_val);
        logic [9:0] fr;
        fr = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            if (i == 0) t_fall = cyc;
            if (i == chg_bit) uart_divide = chg_val;
            repeat (bit_clks) @(negedge clk);
        end
    endtask

    initial begin
        int v0;
        int e0;
        longint lat;
        logic [9:0] fr;

        rst = 1'b1;
        rxd = 1'b1;
        uart_divide = 32'd16;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("rst_data",   {56'd0, uart_rx_data}, 64'h0);
        check("rst_valid",  {63'd0, uart_rx_valid}, 64'h0);
        check("rst_err",    {63'd0, uart_rx_err}, 64'h0);
        check("rst_active", {63'd0, active}, 64'h0);
        rst = 1'b0;
        idle(5);

        // T1: single 0xA5 frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'hA5, 16, 1'b1, -1, 32'd0);
        idle(40);
        check("t1_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("t1_data",      {56'd0, uart_rx_data}, 64'hA5);
        check("t1_err_cnt",   64'(err_cnt - e0), 64'd0);
        check("t1_active",    {63'd0, active}, 64'h0);
        lat = t_valid - t_fall;
        check("t1_latency",   {63'd0, (lat >= 155 && lat <= 157)}, 64'd1);

        // T2: back-to-back 0x00 then 0xFF
        rx_q.delete();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h00, 16, 1'b1, -1, 32'd0);
        send_frame(8'hFF, 16, 1'b1, -1, 32'd0);
        idle(40);
        check("t2_valid_cnt", 64'(valid_cnt - v0), 64'd2);
        check("t2_q_size",    64'(rx_q.size()), 64'd2);
        if (rx_q.size() == 2) begin
            check("t2_byte0", {56'd0, rx_q[0]}, 64'h00);
            check("t2_byte1", {56'd0, rx_q[1]}, 64'hFF);
        end
        check("t2_err_cnt",   64'(err_cnt - e0), 64'd0);

        // T3: 3-clock glitch low
        v0 = valid_cnt; e0 = err_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        check("t3_active_rise", {63'd0, active}, 64'h1);
        repeat (12) @(negedge clk);
        check("t3_active_fall", {63'd0, active}, 64'h0);
        idle(20);
        check("t3_valid_cnt", 64'(valid_cnt - v0), 64'd0);
        check("t3_err_cnt",   64'(err_cnt - e0), 64'd0);

        // T4: 0x3C with low stop bit, line held low 40 bit times
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 16, 1'b0, -1, 32'd0);
        repeat (40 * 16) @(negedge clk);
        check("t4_err_cnt",     64'(err_cnt - e0), 64'd1);
        check("t4_valid_cnt",   64'(valid_cnt - v0), 64'd0);
        check("t4_active_held", {63'd0, active}, 64'h1);
        check("t4_data_kept",   {56'd0, uart_rx_data}, 64'hFF);
        idle(10);
        check("t4_active_fall", {63'd0, active}, 64'h0);
        check("t4_err_once",    64'(err_cnt - e0), 64'd1);

        // T5: reset during data bit 4 of 0x5A, then clean 0x81
        idle(20);
        v0 = valid_cnt; e0 = err_cnt;
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rxd = fr[i];
            repeat (16) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_active", {63'd0, active}, 64'h0);
        check("t5_rst_data",   {56'd0, uart_rx_data}, 64'h00);
        rst = 1'b0;
        idle(200);
        check("t5_no_valid",  64'(valid_cnt - v0), 64'd0);
        check("t5_no_err",    64'(err_cnt - e0), 64'd0);
        send_frame(8'h81, 16, 1'b1, -1, 32'd0);
        idle(40);
        check("t5_valid_cnt", 64'(valid_cnt - v0), 64'd1);
        check("t5_data",      {56'd0, uart_rx_data}, 64'h81);

        // T6: divide change mid-frame, then 32 clk/bit, then clamped divide
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h77, 16, 1'b1, 4, 32'd32);
        idle(64);
        check("t6_valid_77", 64'(valid_cnt - v0), 64'd1);
        check("t6_data_77",  {56'd0, uart_rx_data}, 64'h77);
        send_frame(8'h12, 32, 1'b1, -1, 32'd0);
        idle(80);
        check("t6_valid_12", 64'(valid_cnt - v0), 64'd2);
        check("t6_data_12",  {56'd0, uart_rx_data}, 64'h12);
        uart_divide = 32'd1;
        idle(10);
        send_frame(8'hC3, 4, 1'b1, -1, 32'd0);
        idle(20);
        check("t6_valid_c3", 64'(valid_cnt - v0), 64'd3);
        check("t6_data_c3",  {56'd0, uart_rx_data}, 64'hC3);
        check("t6_err_cnt",  64'(err_cnt - e0), 64'd0);
        check("never_both",  64'(both_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
